// File: rtl/line_kcpe_feeder.sv
// line_kcpe_feeder: answers the 3-PE line conv2d engine's activation/weight requests from BRAM,
// walking the activation region once and the weight region cyclically.
module line_kcpe_feeder #(
   parameter int BIT_WIDTH   = 8,
   parameter int NUM_CHANNEL = 3,
   parameter int NUM_KERNEL  = 4,
   parameter int ADDR_WIDTH  = 16,
   parameter int MEM_LATENCY = 2,
   parameter int REG_WIDTH   = 32
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          i_data_req,
   output logic [BIT_WIDTH*NUM_CHANNEL-1:0]              o_data,
   output logic                                          o_data_val,
   input  logic                                          i_weight_req,
   output logic [BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0]   o_weight,
   output logic                                          o_weight_val,
   output logic                                          o_act_en,
   output logic [ADDR_WIDTH-1:0]                         o_act_addr,
   input  logic [BIT_WIDTH*NUM_CHANNEL-1:0]              i_act_rdata,
   output logic                                          o_wgt_en,
   output logic [ADDR_WIDTH-1:0]                         o_wgt_addr,
   input  logic [BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0]   i_wgt_rdata,
   input  logic [REG_WIDTH-1:0]                          i_conf_ctrl,
   input  logic [REG_WIDTH-1:0]                          i_conf_actbase,
   input  logic [REG_WIDTH-1:0]                          i_conf_actlen,
   input  logic [REG_WIDTH-1:0]                          i_conf_wgtbase,
   input  logic [REG_WIDTH-1:0]                          i_conf_wgtlen,
   output logic                                          o_done
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state;
   logic [ADDR_WIDTH-1:0] act_addr, wgt_addr;
   logic [REG_WIDTH-1:0] act_cnt, wgt_cnt;
   logic [MEM_LATENCY-1:0] act_vp, wgt_vp;
   logic enb, restart, act_issue, wgt_issue, act_last, wgt_wrap, act_out, wgt_out;
   logic unused_bits;
   assign unused_bits = ^{i_conf_ctrl[REG_WIDTH-1:2], i_conf_actbase[REG_WIDTH-1:ADDR_WIDTH],
                          i_conf_wgtbase[REG_WIDTH-1:ADDR_WIDTH]};
   assign enb       = i_conf_ctrl[0];
   assign restart   = i_conf_ctrl[1];
   assign act_issue = state == RUN && enb && !restart && i_data_req && i_conf_actlen != '0;
   assign wgt_issue = (state == RUN || state == DRAIN) && enb && !restart && i_weight_req && i_conf_wgtlen != '0;
   assign act_last  = act_cnt == i_conf_actlen - REG_WIDTH'(1);
   assign wgt_wrap  = wgt_cnt == i_conf_wgtlen - REG_WIDTH'(1);
   assign act_out   = act_vp[MEM_LATENCY-1] && !restart;
   assign wgt_out   = wgt_vp[MEM_LATENCY-1] && !restart;
   assign o_act_en   = act_issue;
   assign o_act_addr = act_issue ? act_addr : '0;
   assign o_wgt_en   = wgt_issue;
   assign o_wgt_addr = wgt_issue ? wgt_addr : '0;
   assign o_done     = state == DONE;
   // restart flushes the valid pipelines so reads already in flight never surface
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         act_addr     <= '0;
         wgt_addr     <= '0;
         act_cnt      <= '0;
         wgt_cnt      <= '0;
         act_vp       <= '0;
         wgt_vp       <= '0;
         o_data       <= '0;
         o_data_val   <= 1'b0;
         o_weight     <= '0;
         o_weight_val <= 1'b0;
      end else begin
         act_vp       <= restart ? '0 : (act_vp << 1) | MEM_LATENCY'(act_issue);
         wgt_vp       <= restart ? '0 : (wgt_vp << 1) | MEM_LATENCY'(wgt_issue);
         o_data_val   <= act_out;
         o_weight_val <= wgt_out;
         if (act_out) o_data <= i_act_rdata;
         if (wgt_out) o_weight <= i_wgt_rdata;
         if (act_issue) begin
            act_addr <= act_addr + ADDR_WIDTH'(1);
            act_cnt  <= act_cnt + REG_WIDTH'(1);
         end
         if (wgt_issue) begin
            wgt_addr <= wgt_wrap ? i_conf_wgtbase[ADDR_WIDTH-1:0] : wgt_addr + ADDR_WIDTH'(1);
            wgt_cnt  <= wgt_wrap ? '0 : wgt_cnt + REG_WIDTH'(1);
         end
         if (restart) state <= IDLE;
         else case (state)
            IDLE: if (enb) begin
               state    <= RUN;
               act_addr <= i_conf_actbase[ADDR_WIDTH-1:0];
               wgt_addr <= i_conf_wgtbase[ADDR_WIDTH-1:0];
               act_cnt  <= '0;
               wgt_cnt  <= '0;
            end
            RUN:   if (i_conf_actlen == '0 || (act_issue && act_last)) state <= DRAIN;
            DRAIN: if (act_vp == '0 && wgt_vp == '0 && !wgt_issue) state <= DONE;
            DONE:  if (!enb) state <= IDLE;
         endcase
      end
   end
endmodule
